disp_mux_7seg: RTL and testbench

- Consumes the divided scan clock `s_clk` from the frequency divider and time-multiplexes four hex digits onto a common-anode 7-segment display.
- The whole block runs on the system clock `clk`. `s_clk` is used only as a level to be edge-detected, never as a clock.
- Provides per-frame snapshotting of the digit values, one-cycle inter-digit blanking against ghosting, and optional leading-zero blanking.

---
 rtl/disp_pkg.sv | 46 ++++
 rtl/disp_mux_7seg_hex.sv | 34 +++
 rtl/disp_mux_7seg.sv | 92 +++++++++
 tb/tb_disp_mux_7seg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan multiplexer.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] AN_OFF  = 4'h0;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Digit k>0 is a leading zero when all nibbles k..3 are zero.
  function automatic logic lz_blank(
    input logic [15:0] v,
    input logic [1:0]  k
  );
    logic r;
    r = 1'b0;
    case (k)
      2'd1:    r = (v[15:4]  == 12'h000);
      2'd2:    r = (v[15:8]  == 8'h00);
      2'd3:    r = (v[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/disp_mux_7seg_hex.sv
// Combinational hex nibble to active-high
// 7-segment pattern decoder.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Map each nibble to its glyph.
  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/disp_mux_7seg.sv
// Four-digit 7-segment scan multiplexer with
// frame snapshot, inter-digit blanking and LZ blanking.
module disp_mux_7seg
  import disp_pkg::*;
#(
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic        s_prev_q;
  logic [1:0]  idx_q, idx_d;
  state_e      state_q, state_d;
  logic [15:0] snap_q, snap_d;
  logic [3:0]  dps_q, dps_d;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  logic        tick;
  logic [3:0]  nib;
  logic [6:0]  seg_hex;
  logic        lz;
  logic [3:0]  an_hi;
  logic [6:0]  seg_hi;
  logic        dp_hi;

  hex_to_7seg u_hex (
    .nib_i (nib),
    .seg_o (seg_hex)
  );

  // Next-state and next-output logic; outputs
  // are derived from next state so they stay registered.
  always_comb begin
    tick    = s_clk & ~s_prev_q;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    snap_d  = snap_q;
    dps_d   = dps_q;
    if (tick && idx_q == 2'd3) begin
      snap_d = digits;
      dps_d  = dp_in;
    end
    state_d = (state_q == SHOW && tick) ? BLANK : SHOW;
    nib     = snap_d[{idx_d, 2'b00} +: 4];
    lz      = BLANK_LZ && lz_blank(snap_d, idx_d);
    an_hi   = AN_OFF;
    seg_hi  = SEG_OFF;
    dp_hi   = 1'b0;
    if (state_d == SHOW) begin
      an_hi  = 4'b0001 << idx_d;
      seg_hi = lz ? SEG_OFF : seg_hex;
      dp_hi  = dps_d[idx_d];
    end
    an_d  = an_hi ^ {4{AN_ACT_LOW}};
    seg_d = seg_hi ^ {7{SEG_ACT_LOW}};
    dp_d  = dp_hi ^ SEG_ACT_LOW;
  end

  // Scan FSM, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q <= 1'b0;
      idx_q    <= 2'd0;
      state_q  <= BLANK;
      snap_q   <= 16'h0000;
      dps_q    <= 4'h0;
      an       <= AN_OFF ^ {4{AN_ACT_LOW}};
      seg      <= SEG_OFF ^ {7{SEG_ACT_LOW}};
      dp       <= SEG_ACT_LOW;
    end else begin
      s_prev_q <= s_clk;
      idx_q    <= idx_d;
      state_q  <= state_d;
      snap_q   <= snap_d;
      dps_q    <= dps_d;
      an       <= an_d;
      seg      <= seg_d;
      dp       <= dp_d;
    end
  end

endmodule

// File: tb/tb_disp_mux_7seg.sv
// Scoreboard bench for disp_mux_7seg.
// A second instance runs with leading-zero blanking off.
module tb_disp_mux_7seg;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_clk;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2;

  always #5 clk = ~clk;

  disp_mux_7seg u_dut (
    .clk    (clk),
    .reset  (reset),
    .s_clk  (s_clk),
    .digits (digits),
    .dp_in  (dp_in),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  disp_mux_7seg #(.BLANK_LZ(1'b0)) u_nlz (
    .clk    (clk),
    .reset  (reset),
    .s_clk  (s_clk),
    .digits (digits),
    .dp_in  (dp_in),
    .an     (an2),
    .seg    (seg2),
    .dp     (dp2)
  );

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [6:0] seg2;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(
    input string      tag,
    input logic [3:0] a,
    input logic [6:0] s,
    input logic       d,
    input logic [6:0] s2
  );
    exp_t e;
    e.tag = tag;
    e.an = a;
    e.seg = s;
    e.dp = d;
    e.seg2 = s2;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".an"}, {4'h0, an}, {4'h0, e.an});
    chk({e.tag, ".seg"}, {1'b0, seg}, {1'b0, e.seg});
    chk({e.tag, ".dp"}, {7'h0, dp}, {7'h0, e.dp});
    chk({e.tag, ".an2"}, {4'h0, an2}, {4'h0, e.an});
    chk({e.tag, ".seg2"}, {1'b0, seg2}, {1'b0, e.seg2});
    chk({e.tag, ".dp2"}, {7'h0, dp2}, {7'h0, e.dp});
  endtask

  task automatic off(input string tag);
    step(tag, 4'hF, 7'h7F, 1'b1, 7'h7F);
  endtask

  task automatic show(
    input string      tag,
    input logic [1:0] k,
    input logic [3:0] nib,
    input logic       dpb,
    input logic       lz
  );
    logic [3:0] a;
    logic [6:0] s;
    a = ~(4'b0001 << k);
    s = lz ? 7'h7F : ~HEX[nib];
    step(tag, a, s, ~dpb, ~HEX[nib]);
  endtask

  task automatic adv(
    input string      tag,
    input logic [1:0] k,
    input logic [3:0] nib,
    input logic       dpb,
    input logic       lz,
    input int         hi,
    input int         lo
  );
    s_clk = 1'b1;
    off({tag, ".blk"});
    repeat (hi - 1) show(tag, k, nib, dpb, lz);
    s_clk = 1'b0;
    repeat (lo) show(tag, k, nib, dpb, lz);
  endtask

  initial begin
    logic [15:0] v;
    reset  = 1'b1;
    s_clk  = 1'b0;
    digits = 16'h0000;
    dp_in  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    off("rst");
    reset = 1'b0;
    show("boot", 2'd0, 4'h0, 1'b0, 1'b0);
    show("boot", 2'd0, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++)
      adv("f0", 2'(k), 4'h0, 1'b0, 1'b1, 4, 4);

    digits = 16'h12AF;
    dp_in  = 4'b0100;
    v = digits;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++)
        adv("scan", 2'(k), v[k*4 +: 4], dp_in[k], 1'b0,
            (f == 1 && k == 2) ? 21 : 4, 4);

    digits = 16'h0050;
    dp_in  = 4'h0;
    adv("lz0", 2'd0, 4'h0, 1'b0, 1'b0, 4, 4);
    adv("lz1", 2'd1, 4'h5, 1'b0, 1'b0, 4, 4);
    adv("lz2", 2'd2, 4'h0, 1'b0, 1'b1, 4, 4);
    adv("lz3", 2'd3, 4'h0, 1'b0, 1'b1, 4, 4);

    digits = 16'h1111;
    adv("mid0", 2'd0, 4'h1, 1'b0, 1'b0, 4, 4);
    digits = 16'h2222;
    adv("mid1", 2'd1, 4'h1, 1'b0, 1'b0, 4, 4);
    adv("mid2", 2'd2, 4'h1, 1'b0, 1'b0, 4, 4);
    adv("mid3", 2'd3, 4'h1, 1'b0, 1'b0, 4, 4);
    adv("new0", 2'd0, 4'h2, 1'b0, 1'b0, 4, 4);
    adv("new1", 2'd1, 4'h2, 1'b0, 1'b0, 4, 4);
    adv("new2", 2'd2, 4'h2, 1'b0, 1'b0, 4, 4);

    reset = 1'b1;
    off("mrst");
    reset = 1'b0;
    show("rec", 2'd0, 4'h0, 1'b0, 1'b0);
    show("rec", 2'd0, 4'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
